// File: rtl/addsub16_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial 16-bit add/subtract unit.
// Saturation support is selected with the ADDSUB16_SAT_EN macro in the top module.
package addsub16_nibble_seq_pkg;

  localparam int NIB_W  = 4;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub16_nibble_seq_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3,
// which the top module uses for signed overflow detection.
module cla4_slice
  import addsub16_nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic             c1;
  logic             c2;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is expanded directly from p/g/cin rather than rippled.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/addsub16_nibble_seq.sv
// Nibble-serial 16-bit signed add/subtract with N/Z/V flags and valid/ready handshakes.
// Define ADDSUB16_SAT_EN to honour the sat input; otherwise results always wrap.
module addsub16_nibble_seq
  import addsub16_nibble_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              sub,
  input  logic              sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              step;
  logic              last;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              carry_q;
  logic [1:0]        idx_q;
  logic [11:0]       sum_q;

  logic [NIB_W-1:0]  a_nib;
  logic [NIB_W-1:0]  b_nib;
  logic [NIB_W-1:0]  s_nib;
  logic              cout;
  logic              c3;
  logic              v_raw;
  logic [DATA_W-1:0] final_res;

`ifdef ADDSUB16_SAT_EN
  logic              sat_q;
`else
  logic              sat_unused;
  assign sat_unused = sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (idx_q == 2'd3) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign a_nib = a_q[{idx_q, 2'b00} +: NIB_W];
  assign b_nib = b_q[{idx_q, 2'b00} +: NIB_W];

  cla4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (cout),
    .c3   (c3)
  );

  // Only meaningful on the final nibble, where cout/c3 belong to bit 15.
  assign v_raw = cout ^ c3;

  always_comb begin
    final_res = {s_nib, sum_q};
`ifdef ADDSUB16_SAT_EN
    if (sat_q && v_raw) final_res = a_q[DATA_W-1] ? SAT_NEG : SAT_POS;
`endif
  end

  // Result and flags load only once the whole word is known, so a partial sum never shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      sum_q   <= '0;
      result  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_v  <= 1'b0;
`ifdef ADDSUB16_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q     <= op_a;
        b_q     <= op_b ^ {DATA_W{sub}};
        carry_q <= sub;
        idx_q   <= 2'd0;
`ifdef ADDSUB16_SAT_EN
        sat_q   <= sat;
`endif
      end
      if (step) begin
        carry_q <= cout;
        idx_q   <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    sum_q[3:0]  <= s_nib;
          2'd1:    sum_q[7:4]  <= s_nib;
          2'd2:    sum_q[11:8] <= s_nib;
          default: ;
        endcase
      end
      if (last) begin
        result <= final_res;
        flag_n <= final_res[DATA_W-1];
        flag_z <= (final_res == '0);
        flag_v <= v_raw;
      end
    end
  end

endmodule

// File: tb/tb_addsub16_nibble_seq.sv
// Self-checking bench for addsub16_nibble_seq; expected results come from an
// arithmetic model and are queued at drive time, then popped when out_valid is seen.
module tb_addsub16_nibble_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        sub       = 1'b0;
  logic        sat       = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] op_a      = 16'h0;
  logic [15:0] op_b      = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;

  wire  [18:0] obs = {result, flag_n, flag_z, flag_v};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [18:0] exp_q[$];

`ifdef ADDSUB16_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  addsub16_nibble_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  // Reference: plain 16-bit arithmetic and sign-rule overflow, packed as {result,N,Z,V}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic st);
    logic [15:0] r;
    logic        v;
    r = s ? (a - b) : (a + b);
    v = s ? ((a[15] != b[15]) && (r[15] != a[15]))
          : ((a[15] == b[15]) && (r[15] != a[15]));
    if (SAT_EN && st && v) r = a[15] ? 16'h8000 : 16'h7FFF;
    return {r, r[15], (r == 16'h0000), v};
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic st);
    op_a     = a;
    op_b     = b;
    sub      = s;
    sat      = st;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b, s, st));
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (obs !== 19'h0) begin
      n_fail++; $display("[TB] FAIL reset_result_flags: got %h expected %h", obs, 19'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [18:0] exp;
    @(negedge clk);
    applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== (i == 4)) begin
        n_fail++; $display("[TB] FAIL basic_latency edge %0d: got %b expected %b", i, out_valid, (i == 4));
      end
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("[TB] FAIL basic_result: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic        ts [6];
    logic        tt [6];
    logic [18:0] exp;
    ta = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'h7FFF};
    tb = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h8000, 16'hFFFF};
    ts = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
    tt = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      applyStimulus(ta[k], tb[k], ts[k], tt[k]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL overflow_case%0d: got valid=%b %h expected valid=1 %h", k, out_valid, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [18:0] held;
    logic [18:0] exp;
    out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(16'h0100, 16'h0200, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    held = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || obs !== held) begin
      n_fail++; $display("[TB] FAIL bp_first_result: got valid=%b %h expected valid=1 %h", out_valid, obs, held);
    end
    @(negedge clk);
    applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== held) begin
        n_fail++;
        $display("[TB] FAIL bp_stall cycle %0d: got valid=%b ready=%b %h expected 1/0 %h", i, out_valid, in_ready, obs, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_second_accept: got in_ready=%b expected 0", in_ready);
    end
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || obs !== exp) begin
      n_fail++; $display("[TB] FAIL bp_second_result: got valid=%b %h expected valid=1 %h", out_valid, obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    logic [18:0] exp;
    @(negedge clk);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 19'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_immediate: got valid=%b ready=%b %h expected 0/1 %h", out_valid, in_ready, obs, 19'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || obs !== 19'h0) begin
        n_fail++; $display("[TB] FAIL async_reset_hold: got valid=%b %h expected 0 %h", out_valid, obs, 19'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL async_reset_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || obs !== exp) begin
      n_fail++; $display("[TB] FAIL async_reset_fresh_op: got valid=%b %h expected valid=1 %h", out_valid, obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic        bs [4];
    logic        bt [4];
    logic [18:0] exp;
    ba = '{16'h0001, 16'h1000, 16'h8000, 16'hABCD};
    bb = '{16'h0002, 16'h0001, 16'h0001, 16'h1234};
    bs = '{1'b0,     1'b1,     1'b1,     1'b0};
    bt = '{1'b0,     1'b0,     1'b1,     1'b0};
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(ba[0], bb[0], bs[0], bt[0]);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL b2b_accept op%0d: got in_ready=%b expected 0", j, in_ready);
      end
      if (j < 3) applyStimulus(ba[j+1], bb[j+1], bs[j+1], bt[j+1]);
      else       in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== (i == 4)) begin
          n_fail++; $display("[TB] FAIL b2b_latency op%0d edge %0d: got %b expected %b", j, i, out_valid, (i == 4));
        end
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("[TB] FAIL b2b_result op%0d: got %h expected %h", j, obs, exp);
      end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL b2b_idle op%0d: got in_ready=%b out_valid=%b expected 1/0", j, in_ready, out_valid);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL b2b_queue_empty: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
